// File: rtl/fc_data_arbiter.sv
// fc_data_arbiter
// Two-master / one-slave in-order data-bus arbiter. Request phases from the
// CPU (m1) and the NVPE accelerator (m2) are arbitrated onto the single L2
// data master (s1). The ID of every accepted request is kept in a small FIFO
// so that each in-order response is routed back to the master that issued it.
//
// Build option:
//   FC_DATA_ARB_RR_EN defined   -> round-robin between the two masters
//   FC_DATA_ARB_RR_EN undefined -> fixed priority, m1 over m2
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   mX_req_i / mX_gnt_o           master request / grant (X = 1, 2)
//   mX_addr_i, mX_we_i, mX_be_i, mX_wdata_i   master request payload
//   mX_rvalid_o, mX_rdata_o       master response
//   s1_req_o / s1_gnt_i           slave request / grant
//   s1_addr_o, s1_we_o, s1_be_o, s1_wdata_o   muxed request payload
//   s1_rvalid_i, s1_rdata_i       slave response
//   outstanding_o                 ID FIFO occupancy
//   protocol_err_o                sticky: response seen with nothing outstanding
module fc_data_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    input  logic                    m2_req_i,
    output logic                    m2_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m2_addr_i,
    input  logic                    m2_we_i,
    input  logic [DATA_WIDTH/8-1:0] m2_be_i,
    input  logic [DATA_WIDTH-1:0]   m2_wdata_i,
    output logic                    m2_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m2_rdata_o,
    output logic                    s1_req_o,
    input  logic                    s1_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s1_addr_o,
    output logic                    s1_we_o,
    output logic [DATA_WIDTH/8-1:0] s1_be_o,
    output logic [DATA_WIDTH-1:0]   s1_wdata_o,
    input  logic                    s1_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s1_rdata_i,
    output logic [3:0]              outstanding_o,
    output logic                    protocol_err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0]       DEPTH    = 4'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t [1:0] mreq;
    logic [1:0] req_v;
    req_t       sel_req;

    assign mreq[0] = {m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i};
    assign mreq[1] = {m2_addr_i, m2_we_i, m2_be_i, m2_wdata_i};
    assign req_v   = {m2_req_i, m1_req_i};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                       lock_vld_q, lock_vld_d;
    logic                       lock_id_q, lock_id_d;
    logic [MAX_OUTSTANDING-1:0] id_mem_q;
    logic [PTR_W-1:0]           wptr_q, rptr_q;
    logic [3:0]                 cnt_q;
    logic                       err_q;
`ifdef FC_DATA_ARB_RR_EN
    logic                       last_q;   // ID of the master granted last
`endif

    logic sel_vld, sel_id;
    logic full, empty, push, pop, head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Selection: a stalled request keeps its master selected (lock) so the
    // payload on s1 stays stable until the slave accepts it.
    // ------------------------------------------------------------------
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        if (lock_vld_q && req_v[lock_id_q]) begin
            sel_vld = 1'b1;
            sel_id  = lock_id_q;
        end else if (req_v == 2'b11) begin
            sel_vld = 1'b1;
`ifdef FC_DATA_ARB_RR_EN
            sel_id  = ~last_q;
`else
            sel_id  = 1'b0;
`endif
        end else if (req_v[0]) begin
            sel_vld = 1'b1;
            sel_id  = 1'b0;
        end else if (req_v[1]) begin
            sel_vld = 1'b1;
            sel_id  = 1'b1;
        end
        // Keep the request side quiet while reset is asserted, even if a
        // master already drives req.
        if (!rst_ni) begin
            sel_vld = 1'b0;
        end
    end

    assign full    = (cnt_q == DEPTH);
    assign empty   = (cnt_q == 4'd0);
    // Full blocks new requests even when a pop happens in the same cycle;
    // this keeps s1_req_o off the response path.
    assign s1_req_o = sel_vld & ~full;
    assign push     = s1_req_o & s1_gnt_i;
    assign pop      = s1_rvalid_i & ~empty;
    assign head_id  = id_mem_q[rptr_q];

    assign sel_req    = sel_vld ? mreq[sel_id] : '0;
    assign s1_addr_o  = sel_req.addr;
    assign s1_we_o    = sel_req.we;
    assign s1_be_o    = sel_req.be;
    assign s1_wdata_o = sel_req.wdata;

    assign m1_gnt_o = push & ~sel_id;
    assign m2_gnt_o = push &  sel_id;

    assign m1_rvalid_o = pop & ~head_id;
    assign m2_rvalid_o = pop &  head_id;
    assign m1_rdata_o  = s1_rdata_i;
    assign m2_rdata_o  = s1_rdata_i;

    assign outstanding_o  = cnt_q;
    assign protocol_err_o = err_q;

    // ------------------------------------------------------------------
    // Lock: set on a stalled request, released on handshake or when the
    // locked master withdraws its request.
    // ------------------------------------------------------------------
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (push || (lock_vld_q && !req_v[lock_id_q])) begin
            lock_vld_d = 1'b0;
        end
        if (s1_req_o && !s1_gnt_i) begin
            lock_vld_d = 1'b1;
            lock_id_d  = sel_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            id_mem_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            if (push) begin
                id_mem_q[wptr_q] <= sel_id;
                wptr_q           <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 4'd1;
                2'b01:   cnt_q <= cnt_q - 4'd1;
                default: cnt_q <= cnt_q;
            endcase
            if (s1_rvalid_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef FC_DATA_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (push) begin
            last_q <= sel_id;
        end
    end
`endif

endmodule

// File: tb/tb_fc_data_arbiter.sv
// Scoreboard bench for fc_data_arbiter. A transaction-level reference model
// (occupancy counter, lock owner, last winner) predicts grants, s1 request
// and payload every cycle; accepted requests push their expected response
// into a scoreboard queue which a separate monitor drains on master rvalid.
// The slave agent answers in order with rdata = addr ^ KEY.
module tb_fc_data_arbiter;

    localparam int MAXO = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam logic [DW-1:0] KEY = 32'h5A5A_C3C3;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    logic [1:0]         mr;
    logic [1:0][AW-1:0] ma;
    logic [1:0]         mw;
    logic [1:0][BW-1:0] mb;
    logic [1:0][DW-1:0] md;

    logic m1_gnt_o, m2_gnt_o, m1_rvalid_o, m2_rvalid_o;
    logic [DW-1:0] m1_rdata_o, m2_rdata_o;
    logic s1_req_o, s1_gnt_i, s1_we_o, s1_rvalid_i, protocol_err_o;
    logic [AW-1:0] s1_addr_o;
    logic [BW-1:0] s1_be_o;
    logic [DW-1:0] s1_wdata_o, s1_rdata_i;
    logic [3:0] outstanding_o;

    always #5 clk_i = ~clk_i;

    fc_data_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m1_req_i(mr[0]), .m1_gnt_o(m1_gnt_o), .m1_addr_i(ma[0]), .m1_we_i(mw[0]),
        .m1_be_i(mb[0]), .m1_wdata_i(md[0]), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .m2_req_i(mr[1]), .m2_gnt_o(m2_gnt_o), .m2_addr_i(ma[1]), .m2_we_i(mw[1]),
        .m2_be_i(mb[1]), .m2_wdata_i(md[1]), .m2_rvalid_o(m2_rvalid_o), .m2_rdata_o(m2_rdata_o),
        .s1_req_o(s1_req_o), .s1_gnt_i(s1_gnt_i), .s1_addr_o(s1_addr_o), .s1_we_o(s1_we_o),
        .s1_be_o(s1_be_o), .s1_wdata_o(s1_wdata_o), .s1_rvalid_i(s1_rvalid_i),
        .s1_rdata_i(s1_rdata_i), .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    typedef struct {
        int           id;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb[$];    // expected responses, in issue order
    logic [AW-1:0] pend[$];  // slave agent: accepted addresses awaiting rvalid

    int   n_cmp = 0;
    int   n_bad = 0;
    int   occ   = 0;         // model: transactions outstanding
    int   lock  = -1;        // model: master owning a stalled request, -1 none
    int   last  = 1;         // model: last granted master
    bit   err_m = 0;
    logic [1:0] g_prev = 2'b00;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Master agent: a granted or new request gets a fresh random payload,
    // a still-waiting request keeps its payload.
    task automatic set_master(input int i, input bit req);
        if (req && (!mr[i] || g_prev[i])) begin
            ma[i] = $urandom;
            mw[i] = 1'($urandom);
            mb[i] = 4'($urandom);
            md[i] = $urandom;
        end
        mr[i] = req;
    endtask

    task automatic set_slave(input bit gnt, input bit rv);
        s1_gnt_i    = gnt;
        s1_rvalid_i = rv;
        s1_rdata_i  = (pend.size() > 0) ? (pend[0] ^ KEY) : DW'($urandom);
    endtask

    // One cycle: inputs are already driven; check and advance the model.
    task automatic step();
        int sel;
        int s;
        bit ereq, hs, pop;
        @(negedge clk_i);
        if (lock >= 0 && mr[lock]) sel = lock;
        else if (mr == 2'b11) begin
`ifdef FC_DATA_ARB_RR_EN
            sel = (last == 0) ? 1 : 0;
`else
            sel = 0;
`endif
        end
        else if (mr[0]) sel = 0;
        else if (mr[1]) sel = 1;
        else sel = -1;
        s    = (sel < 0) ? 0 : sel;
        ereq = (sel >= 0) && (occ < MAXO);
        hs   = ereq && s1_gnt_i;
        pop  = s1_rvalid_i && (occ > 0);

        chk("s1_req", 64'(s1_req_o), 64'(ereq));
        chk("m1_gnt", 64'(m1_gnt_o), 64'(hs && sel == 0));
        chk("m2_gnt", 64'(m2_gnt_o), 64'(hs && sel == 1));
        chk("s1_addr", 64'(s1_addr_o), (sel >= 0) ? 64'(ma[s]) : 64'd0);
        chk("s1_we_be", 64'({s1_we_o, s1_be_o}), (sel >= 0) ? 64'({mw[s], mb[s]}) : 64'd0);
        chk("s1_wdata", 64'(s1_wdata_o), (sel >= 0) ? 64'(md[s]) : 64'd0);
        chk("outstanding", 64'(outstanding_o), 64'(occ));
        chk("protocol_err", 64'(protocol_err_o), 64'(err_m));

        if (s1_rvalid_i && occ == 0) err_m = 1;
        if (hs) sb.push_back('{id: sel, data: ma[s] ^ KEY});
        if (s1_req_o && s1_gnt_i) pend.push_back(s1_addr_o);
        if (s1_rvalid_i && pend.size() > 0) void'(pend.pop_front());
        occ += (hs ? 1 : 0) - (pop ? 1 : 0);
        if (hs) lock = -1;
        else if (ereq && !s1_gnt_i) lock = sel;
        else if (lock >= 0 && !mr[lock]) lock = -1;
        if (hs) last = sel;
        g_prev = {m2_gnt_o, m1_gnt_o};
        @(posedge clk_i);
        #1;
    endtask

    // Response monitor
    always @(negedge clk_i) begin
        if (rst_ni && (m1_rvalid_o || m2_rvalid_o)) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 64'({m2_rvalid_o, m1_rvalid_o}), 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("rsp_route", 64'({m2_rvalid_o, m1_rvalid_o}), (e.id == 0) ? 64'd1 : 64'd2);
                chk("rsp_data", 64'(m2_rvalid_o ? m2_rdata_o : m1_rdata_o), 64'(e.data));
            end
        end
    end

    task automatic drain();
        set_master(0, 0);
        set_master(1, 0);
        for (int i = 0; i < 8; i++) begin
            set_slave(0, pend.size() > 0);
            step();
        end
    endtask

    initial begin
        int cnt1;
        mr = '0; ma = '0; mw = '0; mb = '0; md = '0;
        s1_gnt_i = 0; s1_rvalid_i = 0; s1_rdata_i = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_s1_req", 64'(s1_req_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_err", 64'(protocol_err_o), 64'd0);
        chk("rst_gnt_rvalid", 64'({m1_gnt_o, m2_gnt_o, m1_rvalid_o, m2_rvalid_o}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;

        // Single read from m1, response one cycle after grant
        set_master(0, 1);
        ma[0] = 32'h1C00_0010; mw[0] = 1'b0; mb[0] = 4'hF;
        set_slave(1, 0);
        step();
        set_master(0, 0);
        set_slave(0, 1);
        step();
        set_slave(0, 0);
        step();

        // Contention, slave always grants and answers
        cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            set_master(0, 1);
            set_master(1, 1);
            set_slave(1, pend.size() > 0);
            step();
            cnt1 += int'(g_prev[0]);
        end
`ifdef FC_DATA_ARB_RR_EN
        chk("contention_m1_grants", 64'(cnt1), 64'd4);
`else
        chk("contention_m1_grants", 64'(cnt1), 64'd8);
`endif
        drain();

        // Lock: m2 stalled 3 cycles, m1 joins in cycle 2
        set_master(1, 1); set_slave(0, 0); step();
        set_master(0, 1); step();
        step();
        set_slave(1, 0); step();
        chk("lock_m2_first", 64'(g_prev), 64'd2);
        set_master(1, 0); set_master(0, 1); step();
        chk("lock_m1_next", 64'(g_prev), 64'd1);
        drain();

        // FIFO full: two grants, no responses, then one response
        for (int i = 0; i < 4; i++) begin
            set_master(0, 1); set_slave(1, 0); step();
        end
        set_master(0, 1); set_slave(1, 1); step();
        set_master(0, 1); set_slave(1, 0); step();
        chk("full_reissue", 64'(g_prev), 64'd1);
        drain();

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (mr[i] && !g_prev[i]) set_master(i, ($urandom_range(39) != 0));
                else                     set_master(i, ($urandom_range(99) < 55));
            end
            set_slave(($urandom_range(99) < 70), (pend.size() > 0) && ($urandom_range(99) < 50));
            step();
        end
        drain();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Reset with two transactions outstanding
        set_master(0, 1); set_slave(1, 0); step();
        set_master(0, 1); set_slave(1, 0); step();
        #1;
        rst_ni = 0;
        #1;
        chk("arst_outstanding", 64'(outstanding_o), 64'd0);
        chk("arst_s1_req", 64'(s1_req_o), 64'd0);
        chk("arst_payload", 64'(s1_addr_o), 64'd0);
        chk("arst_gnt", 64'({m1_gnt_o, m2_gnt_o}), 64'd0);
        occ = 0; lock = -1; last = 1; err_m = 0; g_prev = '0;
        sb.delete();
        set_master(0, 0); set_master(1, 0);
        set_slave(0, 0);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;

        // Stale responses after reset: dropped, sticky error
        set_slave(0, 1); step();
        set_slave(0, 1); step();
        set_slave(0, 0); step();
        step();
        chk("err_sticky", 64'(protocol_err_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_data_arbiter.md
# fc_data_arbiter

Two-master, one-slave in-order data-bus arbiter for the fabric-controller subsystem. It sits between the CV32E40P data port (master 1) and the NVPE accelerator data port (master 2) on one side and the L2 data master on the other. It arbitrates request phases, tracks outstanding transactions in an ID FIFO, and routes each response back to the master that issued it.

## Interface
Parameters:
- MAX_OUTSTANDING, 2: depth of the response-routing ID FIFO; legal values 1..8.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; byte-enable width is DATA_WIDTH/8.

Ports (clock and reset first):
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- m1_req_i / m2_req_i  in  1  master request.
- m1_gnt_o / m2_gnt_o  out  1  master grant.
- m1_addr_i / m2_addr_i  in  ADDR_WIDTH  address.
- m1_we_i / m2_we_i  in  1  write enable (1 = write).
- m1_be_i / m2_be_i  in  DATA_WIDTH/8  byte enables.
- m1_wdata_i / m2_wdata_i  in  DATA_WIDTH  write data.
- m1_rvalid_o / m2_rvalid_o  out  1  response valid.
- m1_rdata_o / m2_rdata_o  out  DATA_WIDTH  read data.
- s1_req_o  out  1  slave request.
- s1_gnt_i  in  1  slave grant.
- s1_addr_o, s1_we_o, s1_be_o, s1_wdata_o  out  as above  muxed request payload.
- s1_rvalid_i  in  1  slave response valid.
- s1_rdata_i  in  DATA_WIDTH  slave read data.
- outstanding_o  out  4  current ID FIFO occupancy.
- protocol_err_o  out  1  sticky flag: response received with no transaction outstanding.

## Operation
- Selection is combinational from the requests, the arbitration policy and the lock register.
- s1_req_o = selected master's req AND FIFO not full. Payload is muxed from the selected master; it is all-zero when no master is selected.
- mX_gnt_o = s1_gnt_i AND s1_req_o AND (selected == X). The non-selected master never sees gnt.
- Lock: if s1_req_o=1 and s1_gnt_i=0, the lock register captures the selected master. Next cycle that master stays selected regardless of policy. The lock clears on handshake, or when the locked master drops req (a protocol violation, tolerated).
- Push: the handshake (s1_req_o & s1_gnt_i) writes the master ID (0 = m1, 1 = m2) into the FIFO.
- Pop: s1_rvalid_i with FIFO non-empty pulses rvalid to the head-ID master and pops. The other master's rvalid stays 0.
- s1_rdata_i is broadcast unregistered to both mX_rdata_o. It is valid only with the respective rvalid.
- When the FIFO is full, s1_req_o is forced to 0 even if a pop occurs in the same cycle. Simultaneous push and pop below full are allowed; occupancy is then unchanged.
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- s1_rvalid_i with an empty FIFO is dropped (no master rvalid) and sets protocol_err_o, which is cleared only by reset.

## Timing
- Grant path: zero latency, combinational from mX_req_i and s1_gnt_i to mX_gnt_o.
- Response path: zero latency, s1_rvalid_i to mX_rvalid_o in the same cycle.
- The slave returns rvalid no earlier than the cycle after its gnt. Back-to-back handshakes sustain one transaction per cycle while the FIFO is not full.
- Reset values: all gnt/rvalid 0, s1_req_o 0, payload outputs 0, outstanding_o 0, protocol_err_o 0, lock cleared, FIFO empty, round-robin last-grant = m2.
- Reset mid-operation: in-flight IDs are discarded. Responses arriving after reset set protocol_err_o.

## Configuration
- FC_DATA_ARB_RR_EN defined: round-robin arbitration. When both masters request unlocked, the master not granted last wins. The last-grant register updates on every handshake.
- FC_DATA_ARB_RR_EN undefined: fixed priority, m1 (CPU) over m2. The last-grant register is not implemented.
- The lock and FIFO behaviour are identical in both builds.

## Test plan
- Single read: m1 reads 0x1C00_0010 with slave gnt same cycle and rvalid one cycle later carrying rdata 0xDEAD_BEEF -> m1_gnt 1 cycle, m1_rvalid with 0xDEAD_BEEF; m2_rvalid stays 0; outstanding_o 0→1→0.
- Contention: both masters request continuously, slave always grants -> fixed build: m1 granted every cycle, m2 never; RR build: grants alternate m1,m2,m1,m2.
- Lock: m2 requests alone, slave holds gnt=0 for 3 cycles, m1 requests in cycle 2 -> s1 payload stays m2's for all 3 cycles, m2 granted on the 4th; m1 is granted next.
- FIFO full: MAX_OUTSTANDING=2, slave grants two m1 requests and withholds rvalid -> s1_req_o is 0 with req pending; after one rvalid, the next cycle re-issues; responses return in order m1,m2 for mixed issue m1,m2.
- Error and reset: s1_rvalid_i pulse with empty FIFO -> no master rvalid, protocol_err_o=1 sticky. Reset asserted with 2 outstanding -> outstanding_o=0 and all outputs 0 immediately (asynchronous).
